// File: rtl/prm_pkg.sv
// Shared constants and FSM encoding for the edge-mask scanner.
package prm_pkg;

  localparam int unsigned PRM_CODE_W = 15;
  localparam int unsigned PRM_WORD_W = 32;
  localparam int unsigned PRM_IDX_W  = 12;
  localparam int unsigned PRM_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } prm_state_e;

  // Width of a bit-position index into a WORD_W-bit word (minimum 1).
  function automatic int unsigned prm_pos_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/prm_mask_packer.sv
// Packs per-code mask bits into WORD_W words: one accumulator feeding one
// output register with a valid/ready handshake.
module prm_mask_packer
  import prm_pkg::*;
#(
  parameter int unsigned WORD_W = PRM_WORD_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr_i,
  input  logic                          cap_en_i,
  input  logic                          cap_bit_i,
  input  logic [prm_pos_w(WORD_W)-1:0]  cap_pos_i,
  input  logic                          cap_close_i,
  input  logic                          cap_last_i,
  input  logic                          m_ready_i,
  output logic                          full_o,
  output logic                          m_valid_o,
  output logic [WORD_W-1:0]             m_data_o,
  output logic                          m_last_o,
  output logic [PRM_IDX_W-1:0]          m_idx_o
);

  logic [WORD_W-1:0]    acc_q, acc_d;
  logic                 full_q, full_d;
  logic                 acc_last_q, acc_last_d;
  logic [PRM_IDX_W-1:0] widx_q, widx_d;
  logic                 m_valid_q, m_valid_d;
  logic [WORD_W-1:0]    m_data_q, m_data_d;
  logic                 m_last_q, m_last_d;
  logic [PRM_IDX_W-1:0] m_idx_q, m_idx_d;
  logic                 xfer;

  // A complete accumulator moves out when the output register is empty or draining.
  always_comb begin
    xfer       = full_q & (~m_valid_q | m_ready_i);
    acc_d      = acc_q;
    full_d     = full_q;
    acc_last_d = acc_last_q;
    widx_d     = widx_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    m_idx_d    = m_idx_q;

    if (m_valid_q && m_ready_i) begin
      m_valid_d = 1'b0;
    end

    // Clearing on transfer before the capture lets a new word start in the
    // same cycle the old one leaves, and keeps unfilled high bits zero.
    if (xfer) begin
      m_valid_d  = 1'b1;
      m_data_d   = acc_q;
      m_last_d   = acc_last_q;
      m_idx_d    = widx_q;
      acc_d      = '0;
      full_d     = 1'b0;
      acc_last_d = 1'b0;
      widx_d     = widx_q + PRM_IDX_W'(1);
    end

    if (cap_en_i) begin
      acc_d[cap_pos_i] = cap_bit_i;
      if (cap_close_i) begin
        full_d     = 1'b1;
        acc_last_d = cap_last_i;
      end
    end

    if (clr_i) begin
      acc_d      = '0;
      full_d     = 1'b0;
      acc_last_d = 1'b0;
      widx_d     = '0;
    end
  end

  // Accumulator and output register state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= '0;
      full_q     <= 1'b0;
      acc_last_q <= 1'b0;
      widx_q     <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      m_idx_q    <= '0;
    end else begin
      acc_q      <= acc_d;
      full_q     <= full_d;
      acc_last_q <= acc_last_d;
      widx_q     <= widx_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      m_idx_q    <= m_idx_d;
    end
  end

  assign full_o    = full_q;
  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_last_o  = m_last_q;
  assign m_idx_o   = m_idx_q;

endmodule

// File: rtl/prm_edge_scan.sv
// Sweeps a range of configuration codes through an external combinational
// obstacle checker and streams the returned edge-mask bits as packed words.
module prm_edge_scan
  import prm_pkg::*;
#(
  parameter int unsigned CODE_W = PRM_CODE_W,
  parameter int unsigned WORD_W = PRM_WORD_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CODE_W-1:0]     code_base,
  input  logic [PRM_CNT_W-1:0]  code_count,
  output logic [CODE_W-1:0]     chk_code,
  input  logic                  chk_mask,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WORD_W-1:0]     m_data,
  output logic                  m_last,
  output logic [PRM_IDX_W-1:0]  m_idx,
  output logic                  busy,
  output logic                  done,
  output logic [PRM_CNT_W-1:0]  hit_count
);

  localparam int unsigned POS_W = prm_pos_w(WORD_W);

  prm_state_e           state_q, state_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic [PRM_CNT_W-1:0] i_q, i_d;
  logic [PRM_CNT_W-1:0] count_q, count_d;
  logic [PRM_CNT_W-1:0] hit_q, hit_d;
  logic [POS_W-1:0]     pos_q, pos_d;

  logic pk_full, pk_valid, pk_last;
  logic clr, cap_en, cap_close, last_cap, stall;

  // Next-state, datapath updates and packer controls.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    i_d       = i_q;
    count_d   = count_q;
    hit_d     = hit_q;
    pos_d     = pos_q;
    clr       = 1'b0;
    cap_en    = 1'b0;
    done      = 1'b0;
    last_cap  = (i_q == count_q - PRM_CNT_W'(1));
    stall     = pk_full & pk_valid & ~m_ready;
    cap_close = (pos_q == POS_W'(WORD_W - 1)) | last_cap;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          code_d  = code_base;
          count_d = code_count;
          i_d     = '0;
          pos_d   = '0;
          hit_d   = '0;
          state_d = (code_count == '0) ? ST_FIN : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!stall) begin
          cap_en = 1'b1;
          i_d    = i_q + PRM_CNT_W'(1);
          code_d = code_q + CODE_W'(1);
          pos_d  = (pos_q == POS_W'(WORD_W - 1)) ? '0 : pos_q + POS_W'(1);
          if (chk_mask) begin
            hit_d = hit_q + PRM_CNT_W'(1);
          end
          if (last_cap) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pk_valid && m_ready && pk_last) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and scan datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      i_q     <= '0;
      count_q <= '0;
      hit_q   <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      i_q     <= i_d;
      count_q <= count_d;
      hit_q   <= hit_d;
      pos_q   <= pos_d;
    end
  end

  prm_mask_packer #(
    .WORD_W (WORD_W)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr),
    .cap_en_i    (cap_en),
    .cap_bit_i   (chk_mask),
    .cap_pos_i   (pos_q),
    .cap_close_i (cap_close),
    .cap_last_i  (last_cap),
    .m_ready_i   (m_ready),
    .full_o      (pk_full),
    .m_valid_o   (pk_valid),
    .m_data_o    (m_data),
    .m_last_o    (pk_last),
    .m_idx_o     (m_idx)
  );

  assign m_valid   = pk_valid;
  assign m_last    = pk_last;
  assign busy      = (state_q != ST_IDLE);
  assign chk_code  = (state_q == ST_SCAN) ? code_q : '0;
  assign hit_count = hit_q;

endmodule

// File: tb/tb_prm_edge_scan.sv
// Directed bench for prm_edge_scan with a combinational checker stub.
module tb_prm_edge_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [14:0] code_base;
  logic [15:0] code_count;
  logic [14:0] chk_code;
  logic        chk_mask;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic [11:0] m_idx;
  logic        busy;
  logic        done;
  logic [15:0] hit_count;

  int unsigned mode;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    logic [31:0] data;
    logic [11:0] idx;
    logic        last;
  } word_t;

  word_t words[$];
  int    done_cnt = 0;
  int    mv_cnt   = 0;

  always #5 clk = ~clk;

  // Stub: mode 0 returns code[0]; mode 1 returns code[0]^code[4].
  assign chk_mask = (mode == 0) ? chk_code[0] : (chk_code[0] ^ chk_code[4]);

  prm_edge_scan #(
    .CODE_W (15),
    .WORD_W (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .code_base  (code_base),
    .code_count (code_count),
    .chk_code   (chk_code),
    .chk_mask   (chk_mask),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_idx      (m_idx),
    .busy       (busy),
    .done       (done),
    .hit_count  (hit_count)
  );

  // Record handshaken words, done pulses and valid cycles.
  always @(posedge clk) begin
    if (m_valid && m_ready) words.push_back('{m_data, m_idx, m_last});
    if (done) done_cnt++;
    if (m_valid) mv_cnt++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [14:0] base, input logic [15:0] cnt);
    code_base  = base;
    code_count = cnt;
    start      = 1'b1;
    step;
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      step;
      n++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic chk_word(input string tag, input int pos, input logic [31:0] d,
                          input logic [11:0] idx, input logic last);
    if (pos < words.size()) begin
      chk({tag, "_data"}, 64'(words[pos].data), 64'(d));
      chk({tag, "_idx"},  64'(words[pos].idx),  64'(idx));
      chk({tag, "_last"}, 64'(words[pos].last), 64'(last));
    end else begin
      chk({tag, "_present"}, 64'd0, 64'd1);
    end
  endtask

  initial begin
    int          n;
    int          w0;
    int          d0;
    int          v0;
    logic [31:0] hold_d;
    logic [11:0] hold_i;
    logic        stable;

    // Reset
    rst_n = 1'b0; start = 1'b0; code_base = '0; code_count = '0;
    m_ready = 1'b1; mode = 0;
    step; step;
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_valid", 64'(m_valid),   64'd0);
    chk("rst_data",  64'(m_data),    64'd0);
    chk("rst_idx",   64'(m_idx),     64'd0);
    chk("rst_last",  64'(m_last),    64'd0);
    chk("rst_hits",  64'(hit_count), 64'd0);
    chk("rst_code",  64'(chk_code),  64'd0);
    rst_n = 1'b1;
    step;

    // Single word: base 0, count 32, latency and done timing
    w0 = words.size(); d0 = done_cnt;
    do_start(15'h0000, 16'd32);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_code0", 64'(chk_code), 64'h0);
    n = 0;
    while (m_valid !== 1'b1 && n < 100) begin
      step;
      n++;
    end
    chk("t1_latency", 64'(n), 64'd33);
    chk("t1_data", 64'(m_data), 64'hAAAAAAAA);
    chk("t1_idx", 64'(m_idx), 64'd0);
    chk("t1_last", 64'(m_last), 64'd1);
    chk("t1_hits", 64'(hit_count), 64'd16);
    step;
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_valid_after", 64'(m_valid), 64'd0);
    step;
    chk("t1_done_clear", 64'(done), 64'd0);
    chk("t1_idle", 64'(busy), 64'd0);
    chk("t1_hits_hold", 64'(hit_count), 64'd16);
    chk("t1_words", 64'(words.size() - w0), 64'd1);
    chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Wrap past 0x7FFF, plus a start pulse during SCAN
    w0 = words.size();
    do_start(15'h7FF0, 16'd40);
    for (int k = 0; k < 15; k++) step;
    chk("t2_code_7fff", 64'(chk_code), 64'h7FFF);
    step;
    chk("t2_code_wrap", 64'(chk_code), 64'h0000);
    code_base = 15'h1234; code_count = 16'd5; start = 1'b1;
    step;
    start = 1'b0;
    chk("t2_start_ignored", 64'(chk_code), 64'h0001);
    wait_done(200);
    step;
    chk("t2_words", 64'(words.size() - w0), 64'd2);
    chk_word("t2_w0", w0,     32'hAAAAAAAA, 12'd0, 1'b0);
    chk_word("t2_w1", w0 + 1, 32'h000000AA, 12'd1, 1'b1);
    chk("t2_hits", 64'(hit_count), 64'd20);

    // Backpressure long enough to stall SCAN on a complete accumulator
    mode = 1;
    w0 = words.size();
    do_start(15'h0000, 16'd96);
    n = 0;
    while (m_valid !== 1'b1 && n < 100) begin
      step;
      n++;
    end
    m_ready = 1'b0;
    hold_d = m_data; hold_i = m_idx; stable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step;
      if (m_data !== hold_d || m_idx !== hold_i || m_valid !== 1'b1) stable = 1'b0;
    end
    chk("t3_hold_stable", 64'(stable), 64'd1);
    chk("t3_hold_data", 64'(m_data), 64'h5555AAAA);
    chk("t3_code_frozen", 64'(chk_code), 64'h40);
    step;
    chk("t3_code_frozen2", 64'(chk_code), 64'h40);
    m_ready = 1'b1;
    wait_done(300);
    step;
    chk("t3_words", 64'(words.size() - w0), 64'd3);
    chk_word("t3_w0", w0,     32'h5555AAAA, 12'd0, 1'b0);
    chk_word("t3_w1", w0 + 1, 32'h5555AAAA, 12'd1, 1'b0);
    chk_word("t3_w2", w0 + 2, 32'h5555AAAA, 12'd2, 1'b1);
    chk("t3_hits", 64'(hit_count), 64'd48);
    mode = 0;

    // Zero-length scan
    w0 = words.size(); v0 = mv_cnt;
    do_start(15'h0100, 16'd0);
    chk("t4_busy", 64'(busy), 64'd1);
    chk("t4_done", 64'(done), 64'd1);
    step;
    chk("t4_idle", 64'(busy), 64'd0);
    chk("t4_done_clear", 64'(done), 64'd0);
    chk("t4_no_valid", 64'(mv_cnt - v0), 64'd0);
    chk("t4_hits", 64'(hit_count), 64'd0);

    // Reset in the middle of a scan, then a clean rerun
    w0 = words.size();
    do_start(15'h0000, 16'd100);
    for (int k = 0; k < 20; k++) step;
    chk("t5_code20", 64'(chk_code), 64'd20);
    chk("t5_hits_mid", 64'(hit_count), 64'd10);
    rst_n = 1'b0;
    step;
    d0 = done_cnt;
    chk("t5_rst_busy",  64'(busy),      64'd0);
    chk("t5_rst_valid", 64'(m_valid),   64'd0);
    chk("t5_rst_hits",  64'(hit_count), 64'd0);
    chk("t5_rst_code",  64'(chk_code),  64'd0);
    chk("t5_rst_data",  64'(m_data),    64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step;
    chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t5_no_words", 64'(words.size() - w0), 64'd0);
    do_start(15'h0000, 16'd32);
    wait_done(200);
    step;
    chk("t5_words", 64'(words.size() - w0), 64'd1);
    chk_word("t5_w0", w0, 32'hAAAAAAAA, 12'd0, 1'b1);
    chk("t5_hits", 64'(hit_count), 64'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
